// File: rtl/spi_xfer_ctrl_pkg.sv
// spi_xfer_ctrl_pkg: shared state encoding, default widths and edge-counter sizing
package spi_xfer_ctrl_pkg;
   localparam int DW_DEF = 8;
   localparam int DIV_W_DEF = 8;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_STORE = 2'd2
   } st_e;
   function automatic int edge_w(input int dw);
      return $clog2(2 * dw) + 1;
   endfunction
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: half-period counter, sclk toggling and leading/trailing edge strobes
module spi_sclk_gen
   import spi_xfer_ctrl_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             lvl,
   input  logic [DIV_W-1:0] div,
   output logic             sclk,
   output logic             lead,
   output logic             trail,
   output logic             last
);
   localparam int EW = edge_w(DW);
   localparam logic [EW-1:0] LAST_E = EW'(2 * DW - 1);
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [EW-1:0] edg_q, edg_d;
   logic sclk_q, sclk_d, tick;
   // count each half period, number the edges, park sclk at lvl when not shifting
   always_comb begin
      tick = run & (cnt_q == div);
      cnt_d = (!run || tick) ? '0 : cnt_q + DIV_W'(1);
      edg_d = !run ? '0 : edg_q + EW'(tick);
      sclk_d = !run ? lvl : sclk_q ^ tick;
   end
   // register counter, edge number and sclk
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
         edg_q <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         edg_q <= edg_d;
         sclk_q <= sclk_d;
      end
   end
   assign sclk = sclk_q;
   assign lead = tick & !edg_q[0];
   assign trail = tick & edg_q[0];
   assign last = tick & (edg_q == LAST_E);
endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI master byte sequencer between the TX/RX FIFO pair and the SPI pins
module spi_xfer_ctrl
   import spi_xfer_ctrl_pkg::*;
#(
   parameter int DW    = DW_DEF,
   parameter int DIV_W = DIV_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [DIV_W-1:0] div,
   input  logic             cpol,
   input  logic             cpha,
   input  logic [DW-1:0]    tx_dout,
   input  logic             tx_empty,
   output logic             tx_re,
   output logic [DW-1:0]    rx_din,
   output logic             rx_we,
   input  logic             rx_full,
   output logic             sclk,
   output logic             mosi,
   input  logic             miso,
   output logic             busy,
   output logic             done
);
   st_e st_q, st_d;
   logic [DW-1:0] txsr_q, txsr_d, rxsr_q, rxsr_d, rx_din_q, rx_din_d, src;
   logic [DIV_W-1:0] div_q, div_d;
   logic cpol_q, cpol_d, cpha_q, cpha_d, mosi_q, mosi_d;
   logic start, run, lvl, lead, trail, last, launch, smp;

   spi_sclk_gen #(.DW(DW), .DIV_W(DIV_W)) u_gen (
      .clk   (clk),
      .rst   (rst),
      .run   (run),
      .lvl   (lvl),
      .div   (div_q),
      .sclk  (sclk),
      .lead  (lead),
      .trail (trail),
      .last  (last)
   );

   // sequencing, frame-setting capture and the two shift registers
   always_comb begin
      start = rst & (st_q == ST_IDLE) & en & !tx_empty & !rx_full & !clr;
      run = (st_q == ST_SHIFT) & !clr;
      lvl = (st_q == ST_IDLE || clr) ? cpol : cpol_q;
      launch = start ? !cpha : (cpha_q ? lead : trail & !last);
      smp = cpha_q ? trail : lead;
      src = start ? tx_dout : txsr_q;
      txsr_d = launch ? {src[DW-2:0], 1'b0} : src;
      mosi_d = launch ? src[DW-1] : mosi_q;
      rxsr_d = smp ? {rxsr_q[DW-2:0], miso} : rxsr_q;
      rx_din_d = last ? rxsr_d : rx_din_q;
      div_d = start ? div : div_q;
      cpol_d = start ? cpol : cpol_q;
      cpha_d = start ? cpha : cpha_q;
      st_d = clr ? ST_IDLE :
             start ? ST_SHIFT :
             last ? ST_STORE :
             (st_q == ST_SHIFT) ? ST_SHIFT : ST_IDLE;
   end

   // FSM state and registered datapath
   always_ff @(posedge clk) begin
      if (!rst) begin
         st_q <= ST_IDLE;
         txsr_q <= '0;
         rxsr_q <= '0;
         rx_din_q <= '0;
         div_q <= '0;
         cpol_q <= 1'b0;
         cpha_q <= 1'b0;
         mosi_q <= 1'b0;
      end else begin
         st_q <= st_d;
         txsr_q <= txsr_d;
         rxsr_q <= rxsr_d;
         rx_din_q <= rx_din_d;
         div_q <= div_d;
         cpol_q <= cpol_d;
         cpha_q <= cpha_d;
         mosi_q <= mosi_d;
      end
   end

   assign tx_re = start;
   assign rx_we = rst & (st_q == ST_STORE) & !clr;
   assign done = rx_we;
   assign busy = st_q != ST_IDLE;
   assign mosi = mosi_q;
   assign rx_din = rx_din_q;
endmodule
